// File: rtl/mux_2x1_pkg.sv
// Shared defaults and select encoding for the mux_2x1 slice.
// The output register is built only when MUX2X1_OUT_REG_EN is defined (see mux_2x1.sv).
package mux_2x1_pkg;

    localparam int unsigned DEF_WIDTH = 1;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage

// File: rtl/mux_2x1_sat_cnt.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// The clear input takes priority over increment; the count never wraps past all-ones.
module mux_2x1_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mux_2x1.sv
// 2:1 mux with optional registered output and per-input saturating transfer counters.
// Define MUX2X1_OUT_REG_EN to register out_q/out_valid; otherwise they pass through combinationally.
module mux_2x1
    import mux_2x1_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    sel_e sel;
    assign sel = sel_e'(select);

    // Unknown select resolves to zero in simulation rather than propagating X.
    always_comb begin
        case (sel)
            SEL_A:   out = a;
            SEL_B:   out = b;
            default: out = '0;
        endcase
    end

`ifdef MUX2X1_OUT_REG_EN
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = in_valid;
        if (in_valid) begin
            data_d = out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_q     = data_q;
    assign out_valid = valid_q;
`else
    assign out_q     = out;
    assign out_valid = in_valid;
`endif

    logic inc_a;
    logic inc_b;

    assign inc_a = in_valid && (sel == SEL_A);
    assign inc_b = in_valid && (sel == SEL_B);

    mux_2x1_sat_cnt #(
        .W (CNT_W)
    ) u_cnt_a (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (inc_a),
        .cnt (cnt_a)
    );

    mux_2x1_sat_cnt #(
        .W (CNT_W)
    ) u_cnt_b (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (inc_b),
        .cnt (cnt_b)
    );

endmodule

// File: tb/tb_mux_2x1.sv
// Scoreboard bench for mux_2x1: stimulus pushes expected results, a monitor pops and compares.
// Expectations follow MUX2X1_OUT_REG_EN the same way the design does.
module tb_mux_2x1;

    localparam int unsigned W    = 8;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

`ifdef MUX2X1_OUT_REG_EN
    localparam bit REG_MODE = 1'b1;
`else
    localparam bit REG_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          select;
    logic [W-1:0]  a, b;
    logic          in_valid, cnt_clr;
    logic [W-1:0]  out, out_q;
    logic          out_valid;
    logic [CW-1:0] cnt_a, cnt_b;

    logic          sel1, a1, b1, in_valid1, cnt_clr1;
    logic          out1, out_q1, out_valid1;
    logic [15:0]   cnt_a1, cnt_b1;

    mux_2x1 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .select(select), .a(a), .b(b),
        .in_valid(in_valid), .cnt_clr(cnt_clr), .out(out), .out_q(out_q),
        .out_valid(out_valid), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    mux_2x1 dut1 (
        .clk(clk), .rst(rst), .select(sel1), .a(a1), .b(b1),
        .in_valid(in_valid1), .cnt_clr(cnt_clr1), .out(out1), .out_q(out_q1),
        .out_valid(out_valid1), .cnt_a(cnt_a1), .cnt_b(cnt_b1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] outq;
        logic         ov;
        int           ca;
        int           cb;
    } exp_t;

    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    int           m_ca, m_cb;
    logic [W-1:0] m_outq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: apply one cycle's inputs and queue what the next edge must show.
    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic v, input logic c);
        exp_t         e;
        logic [W-1:0] m;
        @(negedge clk);
        select = s; a = av; b = bv; in_valid = v; cnt_clr = c;
        m = s ? bv : av;
        if (c) begin
            m_ca = 0;
            m_cb = 0;
        end else if (v) begin
            if (s) m_cb = (m_cb < CMAX) ? m_cb + 1 : CMAX;
            else   m_ca = (m_ca < CMAX) ? m_ca + 1 : CMAX;
        end
        if (v) m_outq = m;
        e.out  = m;
        e.outq = REG_MODE ? m_outq : m;
        e.ov   = v;
        e.ca   = m_ca;
        e.cb   = m_cb;
        q.push_back(e);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 rst = 1'b1;
        a = 8'h3C; b = 8'hC3; select = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
        #1;
        chk("rst_out",   out,       8'hC3);
        chk("rst_out_q", out_q,     REG_MODE ? 8'h00 : 8'hC3);
        chk("rst_ov",    out_valid, 1'b0);
        chk("rst_cnt_a", cnt_a,     0);
        chk("rst_cnt_b", cnt_b,     0);
        #1 rst = 1'b0;
        m_ca = 0; m_cb = 0; m_outq = '0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out",       out,       e.out);
                chk("out_q",     out_q,     e.outq);
                chk("out_valid", out_valid, e.ov);
                chk("cnt_a",     cnt_a,     e.ca);
                chk("cnt_b",     cnt_b,     e.cb);
            end
        end
    end

    initial begin
        logic [2:0] v3;
        rst = 1'b1; select = 1'b0; a = 8'h33; b = 8'hCC; in_valid = 1'b1; cnt_clr = 1'b0;
        sel1 = 1'b0; a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b0; cnt_clr1 = 1'b0;
        m_ca = 0; m_cb = 0; m_outq = '0;

        // Exhaustive 1-bit mux while reset holds; in_valid=1 on dut must be ignored.
        for (int i = 0; i < 8; i++) begin
            v3 = 3'(i);
            {b1, a1, sel1} = v3;
            #10;
            chk("w1_out", out1, v3[0] ? v3[2] : v3[1]);
        end
        chk("w1_out_q",  out_q1,     REG_MODE ? 1'b0 : out1);
        chk("w1_ov",     out_valid1, 1'b0);
        chk("w1_cnt_a",  cnt_a1,     0);
        chk("w1_cnt_b",  cnt_b1,     0);
        chk("init_out",   out,       8'h33);
        chk("init_out_q", out_q,     REG_MODE ? 8'h00 : 8'h33);
        chk("init_ov",    out_valid, REG_MODE ? 1'b0 : 1'b1);
        chk("init_cnt_a", cnt_a,     0);
        chk("init_cnt_b", cnt_b,     0);

        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;

        drive(1'b1, 8'h5A, 8'hA5, 1'b1, 1'b0);
        drive(1'b0, 8'h11, 8'h22, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            drive(1'b0, W'($urandom), W'($urandom), 1'b1, 1'b0);
        drive(1'b0, 8'h77, 8'h88, 1'b1, 1'b1);

        for (int i = 0; i < 120; i++)
            drive(1'($urandom % 2), W'($urandom), W'($urandom),
                  ($urandom % 4) != 0, ($urandom % 24) == 0);

        @(posedge clk);
        reset_pulse();

        for (int i = 0; i < 80; i++)
            drive(1'(i % 2), W'($urandom), W'($urandom),
                  ($urandom % 3) != 0, 1'b0);

        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
